// File: rtl/results_collector_if.sv
`default_nettype none
// ============================================================================
// Module      : results_collector_if
// Description : Bundle of signals between results_collector and its
//               environment: run control, the skewed result lanes from the
//               array, status outputs and the read-only BRAM-style
//               processor port.
// Revision    : 1.0 - initial release
// ============================================================================
interface results_collector_if #(
    parameter int LANES  = 32,
    parameter int LANE_W = 16
);
    // Run control and array side
    logic                    start;
    logic [5:0]              batch;
    logic [LANES*LANE_W-1:0] result_out;
    logic [LANES-1:0]        result_out_valid;
    logic                    busy;
    logic                    done;
    logic                    overflow;

    // Processor port (read-only)
    logic                    s_en;
    logic [12:0]             s_addr;
    logic [31:0]             s_din;
    logic [3:0]              s_we;
    logic [31:0]             s_dout;

    // Environment side: drives run control, results and processor requests
    modport master (
        output start, batch, result_out, result_out_valid,
        output s_en, s_addr, s_din, s_we,
        input  busy, done, overflow, s_dout
    );

    // Collector side
    modport slave (
        input  start, batch, result_out, result_out_valid,
        input  s_en, s_addr, s_din, s_we,
        output busy, done, overflow, s_dout
    );
endinterface
`default_nettype wire

// File: rtl/results_collector.sv
`default_nettype none
// ============================================================================
// Module      : results_collector
// Description : Captures 32 skewed 16-bit result lanes into 32 lane-private
//               banks (one write port each, no arbitration) and serves them
//               to a processor as packed 32-bit words {lane 2p+1, lane 2p}.
//               A run is armed by start and stores batch+1 results per lane.
//               Optional feature macro: RESULTS_OVERFLOW_CHECK_EN enables the
//               sticky overflow flag (otherwise overflow reads as 0).
// Revision    : 1.0 - initial release
// ============================================================================
module results_collector #(
    parameter int LANES  = 32,
    parameter int LANE_W = 16,
    parameter int DEPTH  = 64
) (
    input  wire logic          clk,
    input  wire logic          resetn,
    results_collector_if.slave bus
);
    localparam int CNT_W = $clog2(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COLLECT = 2'd1,
        S_DONE    = 2'd2
    } state_t;

    state_t             state_q;
    logic [CNT_W-1:0]   last_k_q;
    logic [CNT_W-1:0]   k_q [LANES];
    // Separate full flags: with last_k = DEPTH-1 the counter wraps to 0.
    logic [LANES-1:0]   full_q;
    logic               busy_q;
    logic               done_q;
    logic               overflow_q;
    logic [31:0]        s_dout_q;
    logic [LANE_W-1:0]  bank_q [LANES][DEPTH];

    logic [LANES-1:0]   wr_en;
    logic               ovf_hit;
    logic [5:0]         rd_e;
    logic [3:0]         rd_p;
    logic               unused_bits;

    assign rd_e = bus.s_addr[11:6];
    assign rd_p = bus.s_addr[5:2];

    // The port is read-only; write data/strobes and the byte offset are ignored.
    assign unused_bits = ^{bus.s_din, bus.s_we, bus.s_addr[1:0], ovf_hit};

    // Per-lane write qualification and detection of valids on full lanes
    always_comb begin
        wr_en   = '0;
        ovf_hit = 1'b0;
        for (int i = 0; i < LANES; i++) begin
            if (state_q == S_COLLECT && bus.result_out_valid[i]) begin
                if (!full_q[i]) begin
                    wr_en[i] = 1'b1;
                end else begin
                    ovf_hit = 1'b1;
                end
            end
        end
    end

    // Run control FSM with lane counters, full flags and registered status
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q    <= S_IDLE;
            last_k_q   <= '0;
            full_q     <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            overflow_q <= 1'b0;
            for (int i = 0; i < LANES; i++) begin
                k_q[i] <= '0;
            end
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (bus.start) begin
                        last_k_q   <= bus.batch;
                        full_q     <= '0;
                        overflow_q <= 1'b0;
                        busy_q     <= 1'b1;
                        state_q    <= S_COLLECT;
                        for (int i = 0; i < LANES; i++) begin
                            k_q[i] <= '0;
                        end
                    end
                end
                S_COLLECT: begin
                    for (int i = 0; i < LANES; i++) begin
                        if (wr_en[i]) begin
                            k_q[i] <= k_q[i] + 1'b1;
                            if (k_q[i] == last_k_q) begin
                                full_q[i] <= 1'b1;
                            end
                        end
                    end
`ifdef RESULTS_OVERFLOW_CHECK_EN
                    if (ovf_hit) begin
                        overflow_q <= 1'b1;
                    end
`endif
                    // Completion is seen one cycle after the last lane fills.
                    if (&full_q) begin
                        state_q <= S_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    // Lane banks: each lane writes its own bank at its own counter (not reset)
    always_ff @(posedge clk) begin
        for (int i = 0; i < LANES; i++) begin
            if (wr_en[i]) begin
                bank_q[i][k_q[i]] <= bus.result_out[i*LANE_W +: LANE_W];
            end
        end
    end

    // Registered processor read; bank reads see pre-write contents
    always_ff @(posedge clk) begin
        if (!resetn) begin
            s_dout_q <= '0;
        end else if (bus.s_en) begin
            if (bus.s_addr[12]) begin
                s_dout_q <= {29'b0, overflow_q, (state_q == S_DONE), busy_q};
            end else begin
                s_dout_q <= {bank_q[{rd_p, 1'b1}][rd_e], bank_q[{rd_p, 1'b0}][rd_e]};
            end
        end
    end

    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.overflow = overflow_q;
    assign bus.s_dout   = s_dout_q;

endmodule
`default_nettype wire

// File: tb/tb_results_collector.sv
`default_nettype none
// ============================================================================
// Module      : tb_results_collector
// Description : Randomized scoreboard bench for results_collector. A
//               behavioural model (per-lane counts and arrays) predicts read
//               data and status; a negedge monitor compares.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_results_collector;
    localparam int LANES = 32;
    localparam int DEPTH = 64;

`ifdef RESULTS_OVERFLOW_CHECK_EN
    localparam bit OVF_EN = 1'b1;
`else
    localparam bit OVF_EN = 1'b0;
`endif

    logic clk    = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    results_collector_if #(.LANES(32), .LANE_W(16)) bus ();

    results_collector #(.LANES(32), .LANE_W(16), .DEPTH(64)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    // Reference model state
    logic [15:0] m_mem   [LANES][DEPTH];
    bit          m_known [LANES][DEPTH];
    int          m_cnt   [LANES];
    int          m_need  = 1;
    int          m_state = 0;          // 0 idle, 1 collecting, 2 done
    bit          m_ovf   = 1'b0;
    bit          m_done  = 1'b0;
    logic [31:0] exp_q [$];
    bit          started = 1'b0;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h want 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] model_read(input logic [12:0] a);
        int e, p;
        e = int'(a[11:6]);
        p = int'(a[5:2]);
        if (a[12]) return {29'b0, m_ovf, (m_state == 2), (m_state == 1)};
        return {m_mem[2*p+1][e], m_mem[2*p][e]};
    endfunction

    // Apply the behaviour of one clock edge to the model, using current inputs
    task automatic model_edge();
        bit all_full;
        if (!resetn) begin
            if (bus.s_en) exp_q.push_back(32'h0);
            m_state = 0;
            m_ovf   = 1'b0;
            m_done  = 1'b0;
            foreach (m_cnt[i]) m_cnt[i] = 0;
            return;
        end
        if (bus.s_en) exp_q.push_back(model_read(bus.s_addr));
        m_done = 1'b0;
        if (m_state != 1) begin
            if (bus.start) begin
                m_need  = int'(bus.batch) + 1;
                m_ovf   = 1'b0;
                m_state = 1;
                foreach (m_cnt[i]) m_cnt[i] = 0;
            end
        end else begin
            all_full = 1'b1;
            foreach (m_cnt[i]) if (m_cnt[i] < m_need) all_full = 1'b0;
            for (int i = 0; i < LANES; i++) begin
                if (bus.result_out_valid[i]) begin
                    if (m_cnt[i] < m_need) begin
                        m_mem[i][m_cnt[i]]   = bus.result_out[i*16 +: 16];
                        m_known[i][m_cnt[i]] = 1'b1;
                        m_cnt[i]++;
                    end else if (OVF_EN) begin
                        m_ovf = 1'b1;
                    end
                end
            end
            if (all_full) begin
                m_state = 2;
                m_done  = 1'b1;
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        started = 1'b1;
        @(negedge clk);
    endtask

    task automatic clear_in();
        bus.start            = 1'b0;
        bus.result_out_valid = '0;
        bus.s_en             = 1'b0;
    endtask

    task automatic set_lane(input int i, input logic [15:0] d);
        bus.result_out_valid[i]     = 1'b1;
        bus.result_out[i*16 +: 16]  = d;
    endtask

    task automatic do_read(input logic [12:0] a);
        bus.s_en   = 1'b1;
        bus.s_addr = a;
        bus.s_din  = $urandom;
        bus.s_we   = 4'($urandom);
    endtask

    // Random read of a fully known word or of the status word
    task automatic rand_read();
        logic [12:0] a;
        int e, p;
        a      = 13'($urandom);
        a[1:0] = 2'b00;
        a[12]  = ($urandom_range(0, 7) == 0);
        e      = int'(a[11:6]);
        p      = int'(a[5:2]);
        if (!a[12] && !(m_known[2*p+1][e] && m_known[2*p][e])) begin
            bus.s_en = 1'b0;
        end else begin
            do_read(a);
        end
    endtask

    // Monitor: read responses from the scoreboard plus per-cycle status
    always @(negedge clk) begin
        if (started) begin
            if (exp_q.size() > 0) check("rdata", bus.s_dout, exp_q.pop_front());
            check("done", 32'(bus.done), 32'(m_done));
            check("busy", 32'(bus.busy), 32'(m_state == 1));
            check("overflow", 32'(bus.overflow), 32'(m_ovf));
        end
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] old_w, new_w;
        logic [15:0] n0, n1;
        int done_seen;
        int n;

        clear_in();
        bus.batch      = 6'd0;
        bus.s_addr     = '0;
        bus.s_din      = '0;
        bus.s_we       = '0;
        bus.result_out = '0;
        resetn         = 1'b0;
        step();
        step();
        check("reset_busy", 32'(bus.busy), 32'd0);
        check("reset_done", 32'(bus.done), 32'd0);
        check("reset_ovf", 32'(bus.overflow), 32'd0);
        check("reset_sdout", bus.s_dout, 32'd0);
        resetn = 1'b1;

        // Skewed lanes, batch = 3
        bus.batch = 6'd3;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        check("busy_after_start", 32'(bus.busy), 32'd1);
        for (int c = 0; c < 35; c++) begin
            bus.result_out_valid = '0;
            for (int i = 0; i < LANES; i++)
                if (c >= i && c <= i + 3) set_lane(i, {8'(i), 8'(c - i)});
            step();
        end
        check("done_not_early", 32'(bus.done), 32'd0);
        clear_in();
        step();
        check("done_one_after_last", 32'(bus.done), 32'd1);
        check("busy_falls_with_done", 32'(bus.busy), 32'd0);
        do_read(13'h004);
        step();
        clear_in();
        check("read_0x004", bus.s_dout, 32'h0300_0200);
        check("done_one_cycle", 32'(bus.done), 32'd0);

        // All lanes every cycle, batch = 63 (counter wrap)
        bus.batch = 6'd63;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        done_seen = 0;
        for (int c = 0; c < 64; c++) begin
            for (int i = 0; i < LANES; i++) set_lane(i, 16'($urandom));
            step();
            if (bus.done) done_seen++;
        end
        clear_in();
        for (int c = 0; c < 4; c++) begin
            step();
            if (bus.done) done_seen++;
        end
        check("done_count_wrap", 32'(done_seen), 32'd1);
        for (int w = 0; w < 1024; w++) begin
            do_read({1'b0, 10'(w), 2'b00});
            step();
        end
        do_read(13'h1000);
        step();
        clear_in();
        check("status_done", bus.s_dout, 32'h2);

        // Lane 5 gets a fifth valid, batch = 3
        bus.batch = 6'd3;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        for (int c = 0; c < 6; c++) begin
            bus.result_out_valid = '0;
            for (int i = 0; i < LANES; i++) begin
                if (i == 5 && c <= 4) set_lane(i, 16'($urandom));
                if (i != 5 && c >= 2) set_lane(i, 16'($urandom));
            end
            step();
        end
        clear_in();
        step();
        check("done_ovf_run", 32'(bus.done), 32'd1);
        check("ovf_port", 32'(bus.overflow), 32'(OVF_EN));
        do_read(13'h1000);
        step();
        check("status_ovf", bus.s_dout, OVF_EN ? 32'h6 : 32'h2);
        do_read(13'h0108);
        step();
        clear_in();

        // Reset in the middle of a run
        do_read(13'h0004);
        step();
        bus.batch = 6'd3;
        bus.start = 1'b1;
        step();
        clear_in();
        for (int c = 0; c < 2; c++) begin
            for (int i = 0; i < LANES; i++) set_lane(i, 16'($urandom));
            step();
        end
        clear_in();
        resetn = 1'b0;
        step();
        check("midrun_reset_busy", 32'(bus.busy), 32'd0);
        check("midrun_reset_done", 32'(bus.done), 32'd0);
        check("midrun_reset_sdout", bus.s_dout, 32'd0);
        resetn = 1'b1;
        // Valids while idle must not write
        for (int c = 0; c < 2; c++) begin
            for (int i = 0; i < LANES; i++) set_lane(i, 16'($urandom));
            step();
        end
        clear_in();
        for (int e = 0; e < 3; e++)
            for (int p = 0; p < 16; p++) begin
                do_read({1'b0, 6'(e), 4'(p), 2'b00});
                step();
            end
        clear_in();

        // Read-before-write on lanes 0/1 entry 0; start with a same-cycle valid
        bus.batch = 6'd3;
        bus.start = 1'b1;
        set_lane(0, 16'hDEAD);
        set_lane(1, 16'hBEEF);
        step();
        clear_in();
        old_w = {m_mem[1][0], m_mem[0][0]};
        n0    = 16'($urandom);
        n1    = 16'($urandom);
        new_w = {n1, n0};
        set_lane(0, n0);
        set_lane(1, n1);
        do_read(13'h0000);
        step();
        clear_in();
        check("rbw_old", bus.s_dout, old_w);
        do_read(13'h0000);
        step();
        clear_in();
        check("rbw_new", bus.s_dout, new_w);

        // start during COLLECT is ignored (batch stays 3, counters kept)
        bus.batch = 6'd10;
        bus.start = 1'b1;
        step();
        clear_in();
        for (int c = 0; c < 4; c++) begin
            for (int i = 0; i < LANES; i++) set_lane(i, 16'($urandom));
            step();
        end
        clear_in();
        step();
        check("start_ignored_done", 32'(bus.done), 32'd1);

        // Randomized runs with interleaved reads and stray starts
        for (int r = 0; r < 6; r++) begin
            bus.batch = 6'($urandom);
            bus.start = 1'b1;
            step();
            bus.start = 1'b0;
            n = 0;
            while (m_state != 2 && n < 3000) begin
                for (int i = 0; i < LANES; i++) begin
                    bus.result_out_valid[i]    = ($urandom_range(0, 1) == 1);
                    bus.result_out[i*16 +: 16] = 16'($urandom);
                end
                bus.start = ($urandom_range(0, 15) == 0);
                bus.batch = 6'($urandom);
                rand_read();
                step();
                n++;
            end
            clear_in();
            step();
            rand_read();
            step();
            clear_in();
        end
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/results_collector.md
# results_collector

Return path of the activation datapath: captures the 32 per-lane 16-bit result words emitted by the array, each lane skewed in time, into 32 lane-private banks. A processor-facing BRAM-style port reads them back as packed 32-bit words. One collection run is armed by `start` and stores `batch+1` results per lane, then signals completion.

## Interface
- `LANES`, 32: result lanes; fixed, since the packing below assumes 32.
- `LANE_W`, 16: result width per lane.
- `DEPTH`, 64: entries per lane bank; must equal 2^width(`batch`).
- `clk` input 1: single clock for the array side and the processor port.
- `resetn` input 1: reset, synchronous and active-low.
- `start` input 1: single-cycle pulse that arms a run.
- `batch` input 6: results per lane minus 1; sampled on an accepted `start`.
- `result_out` input 512: lane i occupies bits [16i+15:16i].
- `result_out_valid` input 32: bit i qualifies lane i this cycle.
- `busy` output 1: high while a run is in COLLECT.
- `done` output 1: one-cycle pulse when every lane has stored `batch+1` results.
- `overflow` output 1: sticky; a valid arrived on a lane that was already full.
- `s_en` input 1: processor port enable.
- `s_addr` input 13: byte address; the word index is `s_addr[11:2]`.
- `s_din` input 32: ignored; the port is read-only.
- `s_we` input 4: ignored; writes have no effect.
- `s_dout` output 32: read data.

## Operation
- FSM has three states: IDLE, COLLECT, DONE.
- Reset, while `resetn` is low on a `clk` edge:
  - state returns to IDLE; all lane counters go to 0.
  - `busy`=0, `done`=0, `overflow`=0, `s_dout`=0.
  - Bank contents are not cleared. A reset mid-run abandons the run; entries already written remain.
- IDLE or DONE with `start`=1:
  - latch `batch` into `last_k`, clear all 32 lane counters `k[i]` (6 bits each) and `overflow`.
  - go to COLLECT.
- `start` in COLLECT is ignored.
- COLLECT, lane i with `result_out_valid[i]`=1:
  - if lane i is not full, write `result_out[16i+15:16i]` into bank i at entry `k[i]`, then increment `k[i]`.
  - a lane is full once it holds `last_k+1` entries. A separate `full[i]` flag is needed because `last_k`=63 wraps the counter.
- Lanes are independent. Any subset, up to all 32, may write in the same cycle; there is no arbitration.
- Valid on a full lane: the data is dropped and the overflow behaviour under Configuration applies.
- Valid while in IDLE or DONE: ignored; no write, no overflow.
- Leave COLLECT for DONE, pulsing `done`, on the cycle after the last lane becomes full.
- DONE holds until the next `start`.
- Processor read, word index w = `s_addr[11:2]`:
  - entry e = w[9:4], pair p = w[3:0].
  - `s_dout` = {bank 2p+1[e], bank 2p[e]}, so the odd lane is in the upper half.
- `s_addr[12]`=1 reads the status word {29'b0, `overflow`, `done`-state, `busy`}, where `done`-state = (state==DONE).

## Timing
- Array-side write: the result is in the bank at the clock edge where valid is sampled.
- `done` is asserted 1 cycle after the edge that stores the final result, and lasts 1 cycle.
- `busy` rises 1 cycle after `start` is sampled and falls together with the `done` pulse.
- Read latency is 1 cycle: `s_dout` is registered on edges where `s_en`=1 and holds its value while `s_en`=0.
- A read and an array write to the same entry in the same cycle return the old data (read-before-write).
- `start` and a lane valid in the same cycle in IDLE or DONE: the valid is ignored; collection starts the next cycle.

## Configuration
- `RESULTS_OVERFLOW_CHECK_EN` defined:
  - a valid on a full lane sets the sticky `overflow` flag.
  - the flag is cleared only by reset or an accepted `start`.
  - the flag is visible on the `overflow` port and in status bit 2.
- Not defined:
  - such valids are silently dropped.
  - `overflow` and status bit 2 are tied to 0.

## Test plan
- Reset with `batch`=3, `start`, then lane i valid at cycles i..i+3 with data {i[7:0],k[7:0]}:
  - `done` pulses 1 cycle after lane 31's fourth result.
  - a read at byte address 0x004 (e=0, p=1) returns 0x0300_0200.
- All 32 lanes valid in the same cycle for 64 cycles with `batch`=63:
  - all 2048 halfwords are stored.
  - `done` pulses once; the counter wrap does not trigger an early or a repeated done.
- Lane 5 gets 5 valids with `batch`=3:
  - entry 4 is untouched.
  - `overflow`=1 with the macro, 0 without it; status word reads 0x6 or 0x2 respectively.
- Assert `resetn`=0 after 2 of 4 results:
  - `busy`=0, `done`=0, `s_dout`=0.
  - entries 0–1 are still readable afterwards.
- Read entry 0 of lanes 0/1 in the same cycle lane 0 writes entry 0: returns the old data; the next read returns the new data.
- `start` during COLLECT: ignored; `batch` and the counters are unchanged.
